// File: rtl/kv_booth_iter_mul.sv
// Iterative radix-4 Booth multiplier: two digits per cycle through a 4:2 compressor, then one carry-propagate add.
// Latency accept->resp_valid = iterations+1 (4 at WIDTH=11); optional early exit under KV_BOOTH_EARLY_TERM_EN.
// Backpressure: resp_valid/resp_prod held in DONE until resp_ready; req_ready high only in IDLE.
module kv_booth_iter_mul #(
    parameter int WIDTH = 11
) (
    input  logic                 core_clk,
    input  logic                 core_reset_n,
    input  logic                 flush,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [WIDTH-1:0]     req_a,
    input  logic [WIDTH-1:0]     req_b,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [2*WIDTH-1:0]   resp_prod
);

    localparam int P  = 2 * WIDTH;
    localparam int D  = (WIDTH + 2) / 2;
    localparam int N  = (D + 1) / 2;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int BW = P + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_ADD  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [P-1:0]  a_reg;
    logic [BW-1:0] b_reg;
    logic [P-1:0]  acc_s;
    logic [P-1:0]  acc_c;

    logic [4:0]    trips;
    logic [P-1:0]  pp0, pp1;
    logic [P-1:0]  s1, c1, s2, c2;
    logic          last_iter;

    // Full two's-complement multiple of a; negation is complete so no separate +1 row.
    function automatic logic [P-1:0] booth_mult(input logic [2:0] trip, input logic [P-1:0] a);
        logic [P-1:0] m;
        case (trip)
            3'b001, 3'b010: m = a;
            3'b011:         m = a << 1;
            3'b100:         m = ~(a << 1) + 1'b1;
            3'b101, 3'b110: m = ~a + 1'b1;
            default:        m = '0;
        endcase
        return m;
    endfunction

    assign req_ready = (state == S_IDLE);

    always_comb begin
        trips = 5'(b_reg >> (4 * int'(cnt)));
        pp0   = '0;
        pp1   = '0;
        if (2 * int'(cnt) < D)
            pp0 = booth_mult(trips[2:0], a_reg) << (4 * int'(cnt));
        if (2 * int'(cnt) + 1 < D)
            pp1 = booth_mult(trips[4:2], a_reg) << (4 * int'(cnt) + 2);

        // 4:2 compression as two chained 3:2 stages; carries past bit P-1 are dropped.
        s1 = acc_s ^ acc_c ^ pp0;
        c1 = ((acc_s & acc_c) | (acc_s & pp0) | (acc_c & pp0)) << 1;
        s2 = s1 ^ c1 ^ pp1;
        c2 = ((s1 & c1) | (s1 & pp1) | (c1 & pp1)) << 1;

        last_iter = (cnt == CW'(N - 1));
`ifdef KV_BOOTH_EARLY_TERM_EN
        // Stop once every multiplier bit from the next digit's boundary upward is zero.
        if ((b_reg >> (4 * int'(cnt) + 3)) == '0)
            last_iter = 1'b1;
`endif
    end

    always_ff @(posedge core_clk or negedge core_reset_n) begin
        if (!core_reset_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            acc_s      <= '0;
            acc_c      <= '0;
            resp_prod  <= '0;
            resp_valid <= 1'b0;
        end else if (flush) begin
            state      <= S_IDLE;
            cnt        <= '0;
            resp_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        a_reg <= P'(req_a);
                        b_reg <= BW'({req_b, 1'b0});
                        acc_s <= '0;
                        acc_c <= '0;
                        cnt   <= '0;
                        state <= S_ITER;
                    end
                end
                S_ITER: begin
                    acc_s <= s2;
                    acc_c <= c2;
                    if (last_iter) begin
                        cnt   <= '0;
                        state <= S_ADD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_ADD: begin
                    resp_prod  <= acc_s + acc_c;
                    resp_valid <= 1'b1;
                    state      <= S_DONE;
                end
                default: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kv_booth_iter_mul.sv
// Scoreboard bench for kv_booth_iter_mul: directed vectors, backpressure, flush, reset, random sweep.
module tb_kv_booth_iter_mul;

    localparam int W = 11;
    localparam int P = 2 * W;
`ifdef KV_BOOTH_EARLY_TERM_EN
    localparam int LAT_SHORT = 2;
`else
    localparam int LAT_SHORT = 4;
`endif

    logic         core_clk = 1'b0;
    logic         core_reset_n = 1'b0;
    logic         flush = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [W-1:0] req_a = '0;
    logic [W-1:0] req_b = '0;
    logic         resp_valid;
    logic         resp_ready = 1'b1;
    logic [P-1:0] resp_prod;

    int chk_cnt = 0;
    int pass_cnt = 0;
    int cyc = 0;
    int acc_cyc = 0;
    bit rand_rr = 1'b0;
    logic [P-1:0] exp_q[$];

    kv_booth_iter_mul #(.WIDTH(W)) dut (
        .core_clk     (core_clk),
        .core_reset_n (core_reset_n),
        .flush        (flush),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_prod    (resp_prod)
    );

    always #5 core_clk = ~core_clk;
    always @(posedge core_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    endtask

    // Monitor: a handshake is decided at the negedge before the edge that completes it.
    always @(negedge core_clk) begin
        if (core_reset_n && resp_valid && resp_ready && !flush) begin
            if (exp_q.size() == 0) check("unexpected_resp", 64'(resp_valid), 64'd0);
            else check("prod", 64'(resp_prod), 64'(exp_q.pop_front()));
        end
    end

    always @(posedge core_clk) begin
        if (rand_rr) begin
            #1;
            resp_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic tick();
        @(posedge core_clk);
        #1;
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [P-1:0] e;
        req_a = a;
        req_b = b;
        req_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge core_clk);
            if (req_ready) break;
        end
        if (!req_ready) begin
            check("accept_timeout", 64'(req_ready), 64'd1);
        end else begin
            e = P'(a) * P'(b);
            exp_q.push_back(e);
            acc_cyc = cyc + 1;
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input string name, input int exp_lat);
        for (int i = 0; i < 50; i++) begin
            @(negedge core_clk);
            if (resp_valid) break;
        end
        check(name, 64'(cyc - acc_cyc), 64'(exp_lat));
    endtask

    task automatic op(input string name, input logic [W-1:0] a, input logic [W-1:0] b, input int lat);
        issue(a, b);
        wait_resp(name, lat);
        tick();
    endtask

    initial begin
        #2;
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_prod", 64'(resp_prod), 64'd0);
        tick();
        tick();
        core_reset_n = 1'b1;
        tick();

        op("lat_7ff", 11'h7FF, 11'h7FF, 4);
        op("lat_400", 11'h400, 11'h400, 4);
        op("lat_5x3", 11'd5, 11'd3, LAT_SHORT);
        op("lat_bzero", 11'h123, 11'h000, LAT_SHORT);
        op("lat_123x456", 11'h123, 11'h456, 4);
        op("lat_azero", 11'h000, 11'h7FF, 4);

        // Backpressure: product 0xAB*0xCD = 0x88EF must sit still.
        resp_ready = 1'b0;
        issue(11'h0AB, 11'h0CD);
        wait_resp("lat_bp", 4);
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge core_clk);
            check("bp_vld", 64'(resp_valid), 64'd1);
            check("bp_prod", 64'(resp_prod), 64'h88EF);
            check("bp_req_rdy", 64'(req_ready), 64'd0);
        end
        tick();
        resp_ready = 1'b1;
        @(posedge core_clk);
        @(negedge core_clk);
        check("bp_idle_rdy", 64'(req_ready), 64'd1);
        check("bp_idle_vld", 64'(resp_valid), 64'd0);
        tick();
        op("lat_9x3", 11'd9, 11'd3, LAT_SHORT);

        // Flush during ITER.
        issue(11'h7FF, 11'h7FF);
        tick();
        flush = 1'b1;
        exp_q.delete();
        tick();
        flush = 1'b0;
        @(negedge core_clk);
        check("flush_iter_vld", 64'(resp_valid), 64'd0);
        check("flush_iter_rdy", 64'(req_ready), 64'd1);
        repeat (6) tick();
        check("flush_iter_quiet", 64'(resp_valid), 64'd0);

        // Flush during DONE: response dropped, resp_prod keeps its value.
        resp_ready = 1'b0;
        issue(11'h200, 11'h003);
        wait_resp("lat_flush_done", LAT_SHORT);
        tick();
        flush = 1'b1;
        exp_q.delete();
        tick();
        flush = 1'b0;
        @(negedge core_clk);
        check("flush_done_vld", 64'(resp_valid), 64'd0);
        check("flush_done_prod", 64'(resp_prod), 64'h600);
        check("flush_done_rdy", 64'(req_ready), 64'd1);
        tick();
        resp_ready = 1'b1;
        repeat (4) tick();
        check("flush_done_quiet", 64'(resp_valid), 64'd0);

        // Asynchronous reset in the middle of ITER.
        issue(11'h7FF, 11'h7FF);
        tick();
        core_reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("arst_req_ready", 64'(req_ready), 64'd1);
        check("arst_resp_valid", 64'(resp_valid), 64'd0);
        check("arst_resp_prod", 64'(resp_prod), 64'd0);
        tick();
        core_reset_n = 1'b1;
        tick();
        op("lat_after_rst", 11'h456, 11'h123, 4);

        rand_rr = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            repeat ($urandom_range(0, 2)) tick();
            issue(11'($urandom), 11'($urandom));
        end
        rand_rr = 1'b0;
        tick();
        tick();
        resp_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        check("drain", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
